// File: rtl/prog_loader.sv
// ============================================================================
// Module   : prog_loader
// Brief    : Byte-stream bootloader that fills program memory and holds the
//            CPU in reset until a checksum-verified image has been received.
//            Optional inter-byte timeout enabled by macro LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [8:0]  words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t     r_state;
  logic [8:0] r_n;
  logic [8:0] r_idx;
  logic [7:0] r_sum;
  logic [7:0] r_hi;

  logic       w_accept;
  logic       w_busy;
  logic       w_timeout;
  logic [7:0] w_sum_next;
  logic [8:0] w_idx_next;

  assign in_ready   = (r_state != S_DONE);
  assign w_accept   = in_valid && in_ready;
  assign w_busy     = (r_state == S_COUNT) || (r_state == S_HI) ||
                      (r_state == S_LO)    || (r_state == S_CSUM);
  assign w_sum_next = r_sum + in_data;
  assign w_idx_next = r_idx + 9'd1;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  // Fires on the cycle whose edge would bring the idle count to TIMEOUT_CYCLES.
  assign w_timeout = w_busy && !w_accept &&
                     (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (!w_busy || w_accept) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES ^ w_busy;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_idx        <= '0;
      r_sum        <= '0;
      r_hi         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (w_timeout) begin
        r_state  <= S_ERR;
        error    <= 1'b1;
        cpu_hold <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept && in_data == SYNC_BYTE) begin
              r_state      <= S_COUNT;
              r_sum        <= '0;
              r_idx        <= '0;
              words_loaded <= '0;
            end
          end
          S_COUNT: begin
            if (w_accept) begin
              r_n     <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
              r_sum   <= in_data;
              r_state <= S_HI;
            end
          end
          S_HI: begin
            if (w_accept) begin
              r_hi    <= in_data;
              r_sum   <= w_sum_next;
              r_state <= S_LO;
            end
          end
          S_LO: begin
            // Write issues from the LO accept so the next HI byte can overlap it.
            if (w_accept) begin
              r_sum        <= w_sum_next;
              mem_we       <= 1'b1;
              mem_addr     <= r_idx[7:0];
              mem_wdata    <= {r_hi, in_data};
              r_idx        <= w_idx_next;
              words_loaded <= words_loaded + 9'd1;
              r_state      <= (w_idx_next == r_n) ? S_CSUM : S_HI;
            end
          end
          S_CSUM: begin
            if (w_accept) begin
              if (w_sum_next == 8'd0) begin
                r_state  <= S_DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                r_state  <= S_ERR;
                error    <= 1'b1;
                cpu_hold <= 1'b1;
              end
            end
          end
          S_DONE: begin
            if (start) begin
              r_state  <= S_IDLE;
              done     <= 1'b0;
              cpu_hold <= 1'b1;
            end
          end
          S_ERR: begin
            if (start) begin
              r_state <= S_IDLE;
              error   <= 1'b0;
            end else if (w_accept && in_data == SYNC_BYTE) begin
              r_state      <= S_COUNT;
              error        <= 1'b0;
              r_sum        <= '0;
              r_idx        <= '0;
              words_loaded <= '0;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream bootloader that writes 16-bit instruction words into the writable program memory of the 8-bit processor.
- Holds the CPU in reset (cpu_hold) until a complete image has been received and its checksum verified.
- Sits between an external byte source (UART receiver or test harness) and the program memory write port. It is the writer side of the program-memory interface the CPU reads from.

Parameters:
- SYNC_BYTE, 8'hA5, header byte that starts a load.
- TIMEOUT_CYCLES, 1000, inter-byte timeout in clk cycles (used only with LOADER_TIMEOUT_EN).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle pulse; re-arms the loader from DONE
- in_valid  input  1  byte source has data
- in_data  input  8  byte value
- in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready at posedge clk
- mem_we  output  1  program memory write strobe
- mem_addr  output  8  program memory word address
- mem_wdata  output  16  instruction word {opcode, reserved, operand}
- cpu_hold  output  1  drives the CPU rst; high while loading or on error
- done  output  1  image loaded and verified
- error  output  1  checksum mismatch or timeout
- words_loaded  output  9  words written in the current/last load

Behaviour:
- Frame format: SYNC_BYTE, N, then N word pairs (high byte first, then low byte), then CSUM.
  - N is the word count; N=0 means 256 words.
  - The frame is valid when (N + all data bytes + CSUM) mod 256 == 0.
- States: IDLE, COUNT, HI, LO, CSUM, DONE, ERR.
- Reset values (async): state=IDLE, cpu_hold=1, done=0, error=0, mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0; sum and timers cleared.
- in_ready is combinational from state: 1 in IDLE, COUNT, HI, LO, CSUM, ERR; 0 in DONE.
- IDLE:
  - A byte equal to SYNC_BYTE -> COUNT; clears sum, word index, and words_loaded.
  - Any other byte is consumed and discarded.
- COUNT: latch N (9-bit; 0 -> 256), sum=N -> HI.
- HI: latch the high byte, sum+=byte -> LO.
- LO: sum+=byte.
  - On the next cycle, mem_we=1 for exactly one cycle with mem_addr=word index and mem_wdata={hi,lo}.
  - After the write, the word index and words_loaded increment.
  - If the word index reaches N -> CSUM, otherwise -> HI.
- Write latency: mem_we is asserted 1 cycle after the LO byte is accepted.
  - Back-to-back bytes still work: the HI byte of the next word is accepted in the same cycle as the write.
- Addresses run 0..N-1. For N=256 the last word goes to 255 and the 8-bit address is never exceeded.
- CSUM: if (sum+byte) mod 256 == 0 -> DONE, else -> ERR.
- DONE:
  - done=1, cpu_hold=0 (registered, asserted the cycle after the CSUM byte is accepted). in_ready=0.
  - start -> IDLE with done=0 and cpu_hold=1 in the next cycle.
- ERR:
  - error=1, cpu_hold=1.
  - Memory contents are undefined, but the CPU never runs a bad image.
  - A SYNC_BYTE byte -> COUNT and clears error. start -> IDLE and clears error. Other bytes are discarded.
- start in any state other than DONE or ERR is ignored.
- Reset mid-load: immediate return to IDLE with cpu_hold=1. Partially written memory is not cleared.
- SYNC_BYTE values are treated as ordinary data when they appear inside a frame (COUNT/HI/LO/CSUM).

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- When defined:
  - A counter runs in COUNT, HI, LO, CSUM and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES with no byte accepted -> ERR (error=1, cpu_hold=1).
  - The counter is idle in IDLE, DONE and ERR.
- When undefined: the loader waits indefinitely for bytes, TIMEOUT_CYCLES is unused, and no counter logic is present.

Test Plan:
- Reset then stream A5,02,60,05,A0,03,F6 (sum 02+60+05+A0+03=0x0A; CSUM=0xF6) -> writes addr0=16'h6005, addr1=16'hA003; words_loaded=2; done=1, cpu_hold=0 one cycle after the CSUM byte.
- Same frame with CSUM=0xF7 -> error=1, cpu_hold stays 1, done=0. Then resend the correct frame -> done=1, error=0.
- Bytes 00,FF,A5,01,F0,00,0F (sum 01+F0+00=0xF1; CSUM=0x0F) -> leading 00,FF discarded; addr0=16'hF000 written; done=1.
- N=0 frame with 256 words (word i = {i,i}; sum of data bytes = 2*(0+…+255) = 0xFF00, so with N=00 the CSUM is 0x00) -> 256 mem_we pulses, last at addr 255; words_loaded=256; done=1.
- Assert rst after the HI byte of the 2nd word -> all outputs return to reset values within the reset cycle; no further mem_we.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=20: send A5,02,60 then stall for 20 cycles -> error=1, cpu_hold=1. Without the macro, the same stall leaves the state in LO and error=0.
